pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 3: total cycles a mul instruction occupies EX; legal range 2..15.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start_i, input, 1 bit: a level that starts instruction flow.
REQ-005 The block SHALL have port IFID_RSaddr1_i, input, 5 bits: rs of the instruction in ID.
REQ-006 The block SHALL have port IFID_RSaddr2_i, input, 5 bits: rt of the instruction in ID.
REQ-007 The block SHALL have port IDEX_control_i, input, 4 bits: op of the instruction in EX, encoded as 0000 or, 0001 and, 0010 add, 0011 sub, 0100 mul, 0101 addi, 0110 lw, 0111 sw, 1000 beq; all others are no-op.
REQ-008 The block SHALL have port IDEX_RDaddr_i, input, 5 bits: destination register of the instruction in EX.
REQ-009 The block SHALL have port branch_taken_i, input, 1 bit: beq in ID resolved taken.
REQ-010 The block SHALL have port PCWrite_o, output, 2 bits: 00 advance PC+4, 01 hold PC, 10 load branch target; 11 is never driven.
REQ-011 The block SHALL have port IFIDWrite_o, output, 1 bit: IF/ID register write enable.
REQ-012 The block SHALL have port IFIDFlush_o, output, 1 bit: clear IF/ID to a no-op.
REQ-013 The block SHALL have port ZeroCtrl_o, output, 1 bit: zero the control fields entering ID/EX (bubble).
REQ-014 The block SHALL have port EXHold_o, output, 1 bit: hold ID/EX and keep the EX unit busy; EX/MEM receives a bubble.

Function
REQ-015 The block SHALL implement states IDLE, RUN and MUL_BUSY, plus a 4-bit down-counter cnt.
REQ-016 All outputs SHALL be combinational functions of the state, cnt and the inputs; only the state, cnt and the optional counters are registered.
REQ-017 In IDLE, outputs SHALL be PCWrite_o=01, IFIDWrite_o=0, ZeroCtrl_o=1, IFIDFlush_o=0 and EXHold_o=0; start_i=1 SHALL move the state to RUN on the next edge.
REQ-018 Once in RUN, start_i SHALL be ignored; only reset returns the block to IDLE.
REQ-019 In RUN, a load-use condition SHALL exist when IDEX_control_i=0110, IDEX_RDaddr_i!=0, and IDEX_RDaddr_i equals either IFID_RSaddr1_i or IFID_RSaddr2_i.
REQ-020 A load-use condition in RUN SHALL drive PCWrite_o=01, IFIDWrite_o=0 and ZeroCtrl_o=1 for exactly one cycle, with the state remaining RUN.
REQ-021 When IDEX_control_i=0100 in RUN, the block SHALL drive PCWrite_o=01, IFIDWrite_o=0, EXHold_o=1 and ZeroCtrl_o=0, load cnt=MUL_LAT-1, and move to MUL_BUSY.
REQ-022 In MUL_BUSY, cnt SHALL decrement each cycle, and the hold outputs of REQ-021 SHALL stay asserted while cnt>1.
REQ-023 In MUL_BUSY with cnt=1, all holds SHALL be released, with PCWrite_o=00 or 10 per REQ-024, and the state SHALL return to RUN; mul EX occupancy is exactly MUL_LAT cycles.
REQ-024 When branch_taken_i=1 in RUN, with no load-use condition and no mul entry, and also in the MUL_BUSY release cycle, the block SHALL drive PCWrite_o=10 and IFIDFlush_o=1 for one cycle.
REQ-025 Priority SHALL be: mul hold (REQ-021/022), then load-use, then branch, then normal operation.
REQ-026 A branch that loses priority SHALL be ignored that cycle; the ID instruction is frozen and re-presents the branch.
REQ-027 Normal RUN operation SHALL drive PCWrite_o=00 and IFIDWrite_o=1, with all other outputs 0.

Reset
REQ-028 While rst_i=0, the block SHALL immediately enter IDLE with cnt=0 and any optional counters at 0, regardless of state, including mid-MUL_BUSY.
REQ-029 Outputs SHALL equal IDLE values during reset, and flow SHALL resume only after start_i is seen high after reset release.

Configuration
REQ-030 With PIPE_HAZARD_CTRL_PERF_EN defined, the block SHALL add outputs stall_cnt_o[15:0] and flush_cnt_o[15:0], each saturating at 16'hFFFF.
REQ-031 stall_cnt_o SHALL count cycles outside IDLE with PCWrite_o=01, and flush_cnt_o SHALL count cycles with IFIDFlush_o=1.
REQ-032 Without PIPE_HAZARD_CTRL_PERF_EN, those ports and registers SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Hold rst_i=0, pulse start_i, then release reset -> IDLE outputs (01,0,1) until start_i=1, then RUN with PCWrite_o=00 the next cycle.
REQ-034 IDEX lw with rd=5 and ID rs=5 -> exactly one cycle of PCWrite_o=01, IFIDWrite_o=0, ZeroCtrl_o=1; with rd=0 -> no stall.
REQ-035 Mul in IDEX with MUL_LAT=3 -> EXHold_o=1 for 2 cycles, then release, EX occupancy 3; repeat with MUL_LAT=2 -> 1 hold cycle.
REQ-036 branch_taken_i=1 together with a load-use condition -> stall only; the next cycle with branch_taken_i=1 -> PCWrite_o=10 and IFIDFlush_o=1.
REQ-037 Assert rst_i=0 during the second MUL_BUSY cycle -> immediate IDLE, EXHold_o=0, cnt=0.
REQ-038 With PIPE_HAZARD_CTRL_PERF_EN, run 70000 forced stall cycles -> stall_cnt_o holds at FFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose    : in-order pipeline hazard control: load-use stall, multi-cycle mul hold, taken-branch flush.
// Latency    : all outputs are combinational from state/cnt/inputs; only state, cnt (and perf counters) register.
// Backpressure: stalls are expressed as PC hold / IF-ID write disable / ID-EX hold; no handshake inputs.
//
// Ports:
//   clk_i, rst_i (async, active-low)    clock and reset
//   start_i                             level; leaves IDLE on the first edge it is seen high
//   IFID_RSaddr1_i / IFID_RSaddr2_i     rs / rt of the instruction in ID
//   IDEX_control_i / IDEX_RDaddr_i      opcode and destination of the instruction in EX
//   branch_taken_i                      beq in ID resolved taken
//   PCWrite_o                           00 PC+4, 01 hold, 10 branch target
//   IFIDWrite_o / IFIDFlush_o           IF/ID write enable / clear to no-op
//   ZeroCtrl_o                          bubble into ID/EX
//   EXHold_o                            hold ID/EX, EX unit busy, bubble into EX/MEM
//   stall_cnt_o / flush_cnt_o           saturating event counters, present only with
//                                       PIPE_HAZARD_CTRL_PERF_EN defined
// Parameter MUL_LAT (2..15): total cycles a mul occupies EX.

module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  IFID_RSaddr1_i,
    input  logic [4:0]  IFID_RSaddr2_i,
    input  logic [3:0]  IDEX_control_i,
    input  logic [4:0]  IDEX_RDaddr_i,
    input  logic        branch_taken_i,
    output logic [1:0]  PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        IFIDFlush_o,
    output logic        ZeroCtrl_o,
    output logic        EXHold_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MUL_BUSY = 2'd2
    } state_t;

    localparam logic [1:0] PC_ADV  = 2'b00;
    localparam logic [1:0] PC_HOLD = 2'b01;
    localparam logic [1:0] PC_BR   = 2'b10;

    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_LW  = 4'b0110;

    // The RUN entry cycle is the first EX cycle of the mul, so the counter
    // covers the remaining MUL_LAT-1 cycles.
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

    state_t     state_q, state_nxt;
    logic [3:0] cnt_q, cnt_nxt;
    logic       is_mul;
    logic       load_use;

    assign is_mul   = (IDEX_control_i == OP_MUL);
    assign load_use = (IDEX_control_i == OP_LW) && (IDEX_RDaddr_i != 5'd0) &&
                      ((IDEX_RDaddr_i == IFID_RSaddr1_i) || (IDEX_RDaddr_i == IFID_RSaddr2_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        PCWrite_o   = PC_ADV;
        IFIDWrite_o = 1'b1;
        IFIDFlush_o = 1'b0;
        ZeroCtrl_o  = 1'b0;
        EXHold_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                PCWrite_o   = PC_HOLD;
                IFIDWrite_o = 1'b0;
                ZeroCtrl_o  = 1'b1;
                if (start_i) begin
                    state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                // Priority: mul hold, load-use, branch, normal. A losing branch is
                // simply dropped; the frozen ID stage re-presents it.
                if (is_mul) begin
                    PCWrite_o   = PC_HOLD;
                    IFIDWrite_o = 1'b0;
                    EXHold_o    = 1'b1;
                    cnt_nxt     = MUL_CNT_INIT;
                    state_nxt   = ST_MUL_BUSY;
                end else if (load_use) begin
                    PCWrite_o   = PC_HOLD;
                    IFIDWrite_o = 1'b0;
                    ZeroCtrl_o  = 1'b1;
                end else if (branch_taken_i) begin
                    PCWrite_o   = PC_BR;
                    IFIDFlush_o = 1'b1;
                end
            end

            ST_MUL_BUSY: begin
                cnt_nxt = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                if (cnt_q > 4'd1) begin
                    PCWrite_o   = PC_HOLD;
                    IFIDWrite_o = 1'b0;
                    EXHold_o    = 1'b1;
                end else begin
                    // Release cycle: the last EX cycle of the mul; ID may advance
                    // or take a pending branch.
                    state_nxt = ST_RUN;
                    if (branch_taken_i) begin
                        PCWrite_o   = PC_BR;
                        IFIDFlush_o = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt   = ST_IDLE;
                cnt_nxt     = 4'd0;
                PCWrite_o   = PC_HOLD;
                IFIDWrite_o = 1'b0;
                ZeroCtrl_o  = 1'b1;
            end
        endcase
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            // IDLE holds the PC too, but that is not a pipeline stall.
            if ((state_q != ST_IDLE) && (PCWrite_o == PC_HOLD) && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (IFIDFlush_o && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
